mbus_timer: RTL

//  Memory-mapped down-counting timer; a responder on the mbus driven by the cpu.

---
 rtl/mbus_timer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mbus_timer.sv
// ---------------------------------------------------------------------------
// mbus_timer
//
// Purpose:
//   Memory-mapped down-counting timer that responds on the cpu mbus. Four word
//   registers sit at BASE_ADDR..BASE_ADDR+3:
//     0 CNT   current count (RW)
//     1 AR    reload value (RW)
//     2 CTRL  [0] RUN, [1] ONESHOT, [2] IE, [15:8] PRESC (RW)
//     3 STAT  [0] OVF sticky (write 1 to clear), [1] RUN copy (read-only)
//   Read data is forced to zero whenever the block is not selected, so the
//   bus-side read mux is a plain OR of all responders.
//
// Ports:
//   clk    in   1          system clock, rising edge
//   reset  in   1          asynchronous, active-high; clears all state
//   addr   in   ADDR_SIZE  word address (cpu mbus_aout)
//   din    in   WIDTH      write data (cpu mbus_dout)
//   wen    in   1          write enable, sampled at the clk edge
//   dout   out  WIDTH      combinational read data (to cpu mbus_din)
//   sel    out  1          high when addr falls inside the register block
//   irq    out  1          OVF & CTRL.IE (only when TIMER_IRQ_EN is defined)
//
// Configuration:
//   TIMER_IRQ_EN  when defined, adds the irq port and the CTRL.IE bit. When
//                 undefined, CTRL[2] is not stored and always reads 0.
// ---------------------------------------------------------------------------
module mbus_timer #(
  parameter int                   WIDTH     = 32,
  parameter int                   ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = ADDR_SIZE'(32'hFFFF_FF40)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 wen,
  output logic [WIDTH-1:0]     dout,
  output logic                 sel
`ifdef TIMER_IRQ_EN
  ,
  output logic                 irq
`endif
);

  // The only control state is whether the counter is running.
  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits of din that a register actually stores; the rest are discarded.
  localparam logic [WIDTH-1:0] USED_MASK = WIDTH'(32'hFFFF_FFFF);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             oneShot_q, oneShot_d;
  logic             ovf_q, ovf_d;
  logic             ieBit;

  logic             writeCnt;
  logic             writeAr;
  logic             writeCtrl;
  logic             writeStat;
  logic             tick;
  logic             tickTaken;
  logic             cntIsZero;
  logic             ctrlStops;
  logic [WIDTH-1:0] readData;
  logic             unusedDin;

  // Block select compares the word address above the two offset bits.
  assign sel = (addr[ADDR_SIZE-1:2] == BASE_ADDR[ADDR_SIZE-1:2]);

  // One write strobe per register; unselected writes never reach a register.
  assign writeCnt  = sel && wen && (addr[1:0] == 2'd0);
  assign writeAr   = sel && wen && (addr[1:0] == 2'd1);
  assign writeCtrl = sel && wen && (addr[1:0] == 2'd2);
  assign writeStat = sel && wen && (addr[1:0] == 2'd3);

  assign cntIsZero = (cnt_q == '0);
  assign ctrlStops = writeCtrl && !din[0];

  // The prescaler reaches PRESC once every PRESC+1 running clocks.
  assign tick = (state_q == RUN) && (pcnt_q == presc_q);

  // A tick is consumed by a CNT write or by a CTRL write that stops the
  // timer on the same edge; in both cases bus software has the last word.
  assign tickTaken = tick && !writeCnt && !ctrlStops;

  assign unusedDin = ^(din & ~USED_MASK);

`ifdef TIMER_IRQ_EN
  logic ie_q, ie_d;

  // Interrupt enable is stored only in the irq build.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q <= 1'b0;
    end else begin
      ie_q <= ie_d;
    end
  end

  // IE follows CTRL writes and holds otherwise.
  always_comb begin
    ie_d = ie_q;
    if (writeCtrl) begin
      ie_d = din[2];
    end
  end

  assign ieBit = ie_q;
  assign irq   = ovf_q && ie_q;
`else
  assign ieBit = 1'b0;
`endif

  // Run/stop state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Start and stop come from CTRL writes; a one-shot also stops itself when
  // its expiry tick reloads the counter, unless a CTRL write says otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (writeCtrl && din[0]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (writeCtrl) begin
          state_d = din[0] ? RUN : STOP;
        end else if (tickTaken && cntIsZero && oneShot_q) begin
          state_d = STOP;
        end
      end
      default: state_d = STOP;
    endcase
  end

  // Datapath registers: count, reload, control fields, prescaler, overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ar_q      <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      oneShot_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ar_q      <= ar_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      oneShot_q <= oneShot_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state datapath. The reload always uses the AR value from before
  // the edge, so an AR write on a reload edge only affects later reloads.
  // An OVF set beats a simultaneous write-one-to-clear.
  always_comb begin
    cnt_d     = cnt_q;
    ar_d      = ar_q;
    presc_d   = presc_q;
    oneShot_d = oneShot_q;
    ovf_d     = ovf_q;
    pcnt_d    = 8'd0;

    if (writeCnt) begin
      cnt_d = din;
    end else if (tickTaken) begin
      cnt_d = cntIsZero ? ar_q : (cnt_q - WIDTH'(1));
    end

    if (writeAr) begin
      ar_d = din;
    end

    if (writeCtrl) begin
      oneShot_d = din[1];
      presc_d   = din[15:8];
    end

    if (tickTaken && cntIsZero) begin
      ovf_d = 1'b1;
    end else if (writeStat && din[0]) begin
      ovf_d = 1'b0;
    end

    // The prescaler only advances while running and staying running; it is
    // parked at 0 in STOP so a restart always begins a full period.
    if ((state_q == RUN) && (state_d == RUN) && !tick) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  // Register read mux; unused CTRL/STAT bits read as zero.
  always_comb begin
    readData = '0;
    case (addr[1:0])
      2'd0: readData = cnt_q;
      2'd1: readData = ar_q;
      2'd2: begin
        readData[0]    = (state_q == RUN);
        readData[1]    = oneShot_q;
        readData[2]    = ieBit;
        readData[15:8] = presc_q;
      end
      2'd3: begin
        readData[0] = ovf_q;
        readData[1] = (state_q == RUN);
      end
      default: readData = '0;
    endcase
  end

  assign dout = sel ? readData : '0;

endmodule
